// File: rtl/alu181_nibble_seq.sv
// Nibble-serial sequencer around one external 74181: a W-bit operation is run
// one 4-bit slice per cycle, LSB first, with the carry rippled through a register.
module alu181_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic [3:0]           op_s,
  input  logic                 op_m,
  input  logic                 op_cn_n,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cn_n,
  input  logic [3:0]           alu_f,
  input  logic                 alu_a_b,
  input  logic                 alu_cn4_n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_f,
  output logic                 out_cn_n,
  output logic                 out_a_b,
  output logic                 out_zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic [W-1:0]  a_q, b_q, res_q;
  logic          eq_q;
  logic [3:0]    alu_a_q, alu_b_q, alu_s_q;
  logic          alu_m_q, alu_cn_n_q;
  logic          out_valid_q, out_cn_n_q, out_a_b_q, out_zero_q;
  logic [W-1:0]  out_f_q;

  logic          accept;
  logic [W-1:0]  res_d;
  logic          eq_d;
  logic [KW-1:0] k_d;

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    res_d = res_q;
    res_d[{k_q, 2'b00} +: 4] = alu_f;
    eq_d  = eq_q & alu_a_b;
    k_d   = k_q + KW'(1);
  end

  // NOTE: state registers use non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      eq_q        <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      alu_m_q     <= 1'b0;
      alu_cn_n_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_cn_n_q  <= 1'b1;
      out_a_b_q   <= 1'b0;
      out_zero_q  <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          res_q <= res_d;
          eq_q  <= eq_d;
          if (k_q == K_LAST) begin
            // Slice operands and carry stay on the bus until the next acceptance.
            state_q     <= DONE;
            k_q         <= '0;
            out_valid_q <= 1'b1;
            out_f_q     <= res_d;
            out_cn_n_q  <= alu_cn4_n;
            out_a_b_q   <= eq_d;
            out_zero_q  <= (res_d == '0);
          end else begin
            k_q        <= k_d;
            alu_a_q    <= a_q[{k_d, 2'b00} +: 4];
            alu_b_q    <= b_q[{k_d, 2'b00} +: 4];
            alu_cn_n_q <= alu_cn4_n;
          end
        end
        default: begin
          if (accept) begin
            state_q     <= RUN;
            k_q         <= '0;
            a_q         <= op_a;
            b_q         <= op_b;
            eq_q        <= 1'b1;
            alu_a_q     <= op_a[3:0];
            alu_b_q     <= op_b[3:0];
            alu_s_q     <= op_s;
            alu_m_q     <= op_m;
            alu_cn_n_q  <= op_cn_n;
            out_valid_q <= 1'b0;
          end else if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign alu_m     = alu_m_q;
  assign alu_cn_n  = alu_cn_n_q;
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;
  assign out_cn_n  = out_cn_n_q;
  assign out_a_b   = out_a_b_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_alu181_nibble_seq.sv
// Bench for alu181_nibble_seq: emulates the external 74181 and checks the DUT
// every cycle against a whole-word model of each accepted operation.
module tb_alu181_nibble_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   op_s;
  logic         op_m, op_cn_n;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_cn_n, alu_a_b, alu_cn4_n;
  logic         out_valid, out_ready;
  logic [W-1:0] out_f;
  logic         out_cn_n, out_a_b, out_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu181_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cn_n(op_cn_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn_n(alu_cn_n),
    .alu_f(alu_f), .alu_a_b(alu_a_b), .alu_cn4_n(alu_cn4_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_cn_n(out_cn_n), .out_a_b(out_a_b), .out_zero(out_zero)
  );

  // 74181 with active-high data over the low 'bits' bits: arithmetic is
  // t1 + t2 + carry, logic is ~(t1 ^ t2). Returns {carry_out_n, f}.
  function automatic logic [W:0] alu_eval(input logic [W-1:0] a, b, input logic [3:0] s,
                                          input logic m, cn_n, input int bits);
    logic [W-1:0] mask, t1, t2, f;
    logic [W:0]   sum;
    mask = (bits >= W) ? '1 : ((W'(1) << bits) - W'(1));
    t1   = (a | (b & {W{s[0]}}) | (~b & {W{s[1]}})) & mask;
    t2   = ((a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}})) & mask;
    sum  = {1'b0, t1} + {1'b0, t2} + {{W{1'b0}}, ~cn_n};
    f    = (m ? ~(t1 ^ t2) : sum[W-1:0]) & mask;
    return {~sum[bits], f};
  endfunction

  logic [W:0] alu_r;
  always_comb alu_r = alu_eval({{(W-4){1'b0}}, alu_a}, {{(W-4){1'b0}}, alu_b},
                               alu_s, alu_m, alu_cn_n, 4);
  assign alu_f     = alu_r[3:0];
  assign alu_cn4_n = alu_r[W];
  assign alu_a_b   = (alu_r[3:0] == 4'hF);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- whole-operation model ----------------
  typedef struct {
    logic [W-1:0] a, b;
    logic [3:0]   s;
    logic         m, cn;
    int           acc, due;
    logic [W-1:0] f;
    logic         cn_o, ab, zero;
  } op_t;

  op_t        q[$];
  int         cyc = 0;
  op_t        ne;
  logic [W:0] nr;
  logic       m_hv, m_rdy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cyc = 0;
    end else begin
      m_hv  = (q.size() > 0) && (cyc >= q[0].due);
      m_rdy = (q.size() == 0) || (m_hv && out_ready);
      if (m_hv && out_ready) void'(q.pop_front());
      if (in_valid && m_rdy) begin
        nr      = alu_eval(op_a, op_b, op_s, op_m, op_cn_n, W);
        ne.a    = op_a;  ne.b = op_b;  ne.s = op_s;  ne.m = op_m;  ne.cn = op_cn_n;
        ne.acc  = cyc + 1;
        ne.due  = cyc + 1 + N;
        ne.f    = nr[W-1:0];
        ne.cn_o = nr[W];
        ne.ab   = (nr[W-1:0] == '1);
        ne.zero = (nr[W-1:0] == '0);
        q.push_back(ne);
      end
      cyc++;
    end
  end

  logic         c_ev, c_er, c_cin;
  logic [W-1:0] c_sh;
  logic [W:0]   c_r;
  int           c_j;

  always @(negedge clk) begin
    c_ev = (q.size() > 0) && (cyc >= q[0].due);
    c_er = (q.size() == 0) || (c_ev && out_ready);
    check("out_valid", out_valid, c_ev);
    check("in_ready", in_ready, c_er);
    if (c_ev) begin
      check("out_f", out_f, q[0].f);
      check("out_cn_n", out_cn_n, q[0].cn_o);
      check("out_a_b", out_a_b, q[0].ab);
      check("out_zero", out_zero, q[0].zero);
    end else if (q.size() > 0) begin
      c_j = cyc - q[0].acc;
      c_r = alu_eval(q[0].a, q[0].b, q[0].s, q[0].m, q[0].cn, 4 * c_j);
      c_cin = (c_j == 0) ? q[0].cn : c_r[W];
      c_sh = q[0].a >> (4 * c_j);
      check("alu_a", alu_a, c_sh[3:0]);
      c_sh = q[0].b >> (4 * c_j);
      check("alu_b", alu_b, c_sh[3:0]);
      check("alu_s", alu_s, q[0].s);
      check("alu_m", alu_m, q[0].m);
      check("alu_cn_n", alu_cn_n, c_cin);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cn);
    bit ok = 0;
    in_valid = 1'b1;  op_a = a;  op_b = b;  op_s = s;  op_m = m;  op_cn_n = cn;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 1, 0);
  endtask

  // Ends on the negedge where out_valid is first seen; ecn/eab < 0 skip that flag.
  task automatic wait_result(input logic [W-1:0] ef, input int ecn, input int eab, input int ez);
    int n = 0;
    bit seen = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("result_seen", seen, 1);
    check("latency", n, N);
    check("lit_out_f", out_f, ef);
    if (ecn >= 0) check("lit_out_cn_n", out_cn_n, ecn[0]);
    if (eab >= 0) check("lit_out_a_b", out_a_b, eab[0]);
    check("lit_out_zero", out_zero, ez[0]);
  endtask

  task automatic do_op(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cn,
                       input logic [W-1:0] ef, input int ecn, input int eab, input int ez);
    send(a, b, s, m, cn);
    wait_result(ef, ecn, eab, ez);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_f", out_f, 0);
    check("rst_out_cn_n", out_cn_n, 1);
    check("rst_out_a_b", out_a_b, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_s", alu_s, 0);
    check("rst_alu_m", alu_m, 0);
    check("rst_alu_cn_n", alu_cn_n, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;  in_valid = 1'b0;  out_ready = 1'b1;
    op_a = '0;  op_b = '0;  op_s = '0;  op_m = 1'b0;  op_cn_n = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // arithmetic, carry ripple, equality, logic mode
    do_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1, 0, 0);
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 0, 0, 1);
    do_op(16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1, 1, 0);
    do_op(16'h3C3C, 16'h3C3D, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1, 0, 0);
    do_op(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1, 16'hF000, -1, 0, 0);
    do_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, -1, 0, 0);
    do_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0003, 1, 0, 0);

    // backpressure for three cycles, then back-to-back acceptance on the handshake edge
    out_ready = 1'b0;
    send(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
    wait_result(16'h2233, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_f", out_f, 16'h2233);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'h00FF, 16'h0000, 4'b0000, 1'b0, 1'b0);
    wait_result(16'h0100, 1, 0, 0);
    @(posedge clk);
    #1;

    // reset while the third slice is on the bus
    send(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    do_op(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1, 16'h3333, 1, 0, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu181_nibble_seq.md
ALU181_NIBBLE_SEQ -- requirements
Module: alu181_nibble_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: nibble slices per operation; operand/result width is 4*NIBBLES (W).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have inputs in_valid (1), op_a (W), op_b (W), op_s (4), op_m (1) and op_cn_n (1): request handshake and operation, with 74181 select/mode and active-low carry-in.
REQ-005 SHALL have output in_ready (1): request accepted on the edge where in_valid and in_ready are both 1.
REQ-006 SHALL have outputs alu_a (4), alu_b (4), alu_s (4), alu_m (1) and alu_cn_n (1), driving the a/b/s/m/cn_n pins of one external alu181.
REQ-007 SHALL have inputs alu_f (4), alu_a_b (1) and alu_cn4_n (1), taken from that alu181; its x/y pins are unused.
REQ-008 SHALL have outputs out_valid (1), out_f (W), out_cn_n (1), out_a_b (1) and out_zero (1), plus input out_ready (1): result handshake and flags.

Function
REQ-009 SHALL implement FSM states IDLE, RUN and DONE.
REQ-010 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-011 SHALL, on acceptance, latch op_a/op_b/op_s/op_m, clear nibble index k to 0, set carry register to op_cn_n, and enter RUN.
REQ-012 SHALL, in RUN, drive alu_a=A[4k+3:4k], alu_b=B[4k+3:4k], alu_s/alu_m from the latched values, and alu_cn_n from the carry register.
REQ-013 SHALL, at each RUN edge:
- store alu_f into result nibble k;
- load alu_cn4_n into the carry register;
- AND alu_a_b into an equality accumulator (initialised to 1 on acceptance);
- increment k.
REQ-014 SHALL go RUN->DONE on the edge that samples nibble NIBBLES-1; out_valid is first high exactly NIBBLES edges after the acceptance edge.
REQ-015 SHALL hold out_valid=1 and all out_* stable in DONE until out_valid & out_ready; then go to IDLE, or to RUN if in_valid is also 1 (back-to-back acceptance, zero bubble).
REQ-016 SHALL set out_cn_n = alu_cn4_n of the last nibble, out_a_b = equality accumulator, and out_zero = (out_f == 0).
REQ-017 SHALL ripple carry identically when op_m=1; the ALU ignores carry in logic mode and the sequencer does not special-case it.
REQ-018 SHALL ignore in_valid during RUN and ignore out_ready outside DONE.
REQ-019 SHALL, in IDLE and DONE, keep alu_* at their last driven values (no glitching to new operands until acceptance).

Reset
REQ-020 SHALL, on rst, immediately force:
- state=IDLE, k=0;
- in_ready=1, out_valid=0;
- out_f=0, out_cn_n=1, out_a_b=0, out_zero=1;
- alu_a=alu_b=alu_s=0, alu_m=0, alu_cn_n=1.
REQ-021 SHALL, on rst asserted mid-RUN or in DONE, discard the operation and produce no out_valid for it.

Verification
REQ-022 SHALL be verified for add: op_s=1001, m=0, cn_n=1, A=0x1234, B=0x0FFF -> out_f=0x2233, out_cn_n=1, out_zero=0, out_valid at acceptance+4 edges.
REQ-023 SHALL be verified for carry ripple: op_s=1001, m=0, cn_n=1, A=0xFFFF, B=0x0001 -> out_f=0x0000, out_cn_n=0, out_zero=1.
REQ-024 SHALL be verified for equality: op_s=0110, m=0, cn_n=1, A=B=0x3C3C -> out_f=0xFFFF, out_a_b=1; with B=0x3C3D -> out_a_b=0.
REQ-025 SHALL be verified for logic: op_s=1011, m=1, A=0xF0F0, B=0xFF00 -> out_f=0xF000; then op_s=0110, m=1 -> out_f=0x0FF0.
REQ-026 SHALL be verified for backpressure and back-to-back: hold out_ready=0 for 3 cycles in DONE -> out_* stable, in_ready=0; then out_ready=1 with in_valid=1 -> next request accepted on the same edge, next out_valid 4 edges later.
REQ-027 SHALL be verified for mid-operation reset: assert rst at RUN k=2 -> out_valid stays 0, in_ready=1, all outputs at REQ-020 values; the next request completes correctly.
